// File: rtl/keypad10_debounce_pkg.sv
// Shared types and helpers for the decimal keypad front end.
package keypad10_pkg;

  localparam int NKEYS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2,
    REL   = 2'd3
  } kp_state_t;

  // Number of key lines currently asserted (0..10 fits in 4 bits).
  function automatic logic [3:0] popcount10(input logic [NKEYS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NKEYS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // True when exactly one key line is asserted.
  function automatic logic onehot10(input logic [NKEYS-1:0] v);
    return (popcount10(v) == 4'd1);
  endfunction

endpackage

// File: rtl/keypad10_debounce_sync_2ff.sv
// Two-flop synchroniser bringing asynchronous key lines into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the raw lines through two stages; the second stage is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad10_debounce.sv
// Keypad front end: synchronise, debounce press/release, reject multi-key
// presses, and present a held one-hot word plus a one-cycle accept strobe.
module keypad10_debounce
  import keypad10_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] d,
  output logic             key_valid,
  output logic             key_held,
  output logic             multi_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Counting stops at this value, so the counter can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] key_s;

  kp_state_t        state_q, state_d;
  logic [NKEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             multi_q, multi_d;

  sync_2ff #(
    .WIDTH(NKEYS)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(key_raw),
    .sync_o (key_s)
  );

  // State, candidate, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  // Debounce FSM: press needs DEBOUNCE_CYCLES matching samples, release too.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = (popcount10(key_s) >= 4'd2);

    case (state_q)
      IDLE: begin
        dout_d = '0;
        held_d = 1'b0;
        if (onehot10(key_s)) begin
          cand_d  = key_s;
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (key_s != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          dout_d  = cand_q;
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (key_s != cand_q) begin
          state_d = REL;
          cnt_d   = '0;
        end
      end
      REL: begin
        if (key_s == cand_q) begin
          // Release bounce: the key came back, keep holding without a new strobe.
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          dout_d  = '0;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign d         = dout_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_err = multi_q;

endmodule

// File: tb/tb_keypad10_debounce.sv
// Scoreboard bench for keypad10_debounce with DEBOUNCE_CYCLES = 4.
module tb_keypad10_debounce;

  localparam int N   = 4;
  localparam int LAT = N + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key_raw = 10'h000;
  logic [9:0] d;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  keypad10_debounce #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_raw),
    .d        (d),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit         is_rel;
    logic [9:0] val;
    int         at_edge;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a key and expect its accept strobe LAT edges later.
  task automatic press(input logic [9:0] v);
    key_raw = v;
    exp_q.push_back('{1'b0, v, edge_cnt + LAT});
  endtask

  // Release all keys and expect d to return to zero LAT edges later.
  task automatic release_key();
    key_raw = 10'h000;
    exp_q.push_back('{1'b1, 10'h000, edge_cnt + LAT});
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or releases.
  logic [9:0] d_prev = 10'h000;
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        d_prev = 10'h000;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
          ev = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event: got nothing expected %s d=%0h at edge %0d",
                   ev.is_rel ? "release" : "accept", ev.val, ev.at_edge);
        end
        check("d_onehot_or_zero", 32'($countones(d) <= 1), 32'd1);
        if (key_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got key_valid d=%0h expected none at edge %0d", d, edge_cnt);
          end else begin
            ev = exp_q.pop_front();
            check("valid_kind", 32'(ev.is_rel), 32'd0);
            check("valid_d", 32'(d), 32'(ev.val));
            check("valid_edge", edge_cnt, ev.at_edge);
            check("valid_held", 32'(key_held), 32'd1);
          end
        end
        if (d_prev != 10'h000 && d == 10'h000) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_release: got d=0 expected held d=%0h at edge %0d", d_prev, edge_cnt);
          end else begin
            ev = exp_q.pop_front();
            check("rel_kind", 32'(ev.is_rel), 32'd1);
            check("rel_edge", edge_cnt, ev.at_edge);
            check("rel_held", 32'(key_held), 32'd0);
          end
        end
        d_prev = d;
      end
    end
  end

  // Stimulus
  initial begin
    int e0;
    rst_n   = 1'b0;
    key_raw = 10'h000;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst_d", 32'(d), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_multi", 32'(multi_err), 32'd0);

    // Clean press and release of bit3.
    press(10'h008);
    cyc(10);
    check("clean_held", 32'(key_held), 32'd1);
    check("clean_d", 32'(d), 32'h008);
    cyc(10);
    release_key();
    cyc(12);

    // Press bounce on bit2, then a stable press.
    for (int k = 0; k < 5; k++) begin
      key_raw = (k % 2 == 1) ? 10'h004 : 10'h000;
      cyc(2);
    end
    press(10'h004);
    cyc(20);
    release_key();
    cyc(12);

    // Release bounce while bit9 is held.
    press(10'h200);
    cyc(12);
    key_raw = 10'h000;
    cyc(2);
    key_raw = 10'h200;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      check("relbounce_d", 32'(d), 32'h200);
      check("relbounce_held", 32'(key_held), 32'd1);
    end
    release_key();
    cyc(12);

    // Two keys at once: multi_err from edge 3, no accept.
    e0 = edge_cnt;
    key_raw = 10'h011;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("multi_on", 32'(multi_err), 32'(edge_cnt >= e0 + 3));
      check("multi_d", 32'(d), 32'd0);
    end
    e0 = edge_cnt;
    press(10'h001);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("multi_off", 32'(multi_err), 32'(edge_cnt < e0 + 3));
    end
    cyc(4);
    release_key();
    cyc(12);

    // Walk all ten keys.
    for (int i = 0; i < 10; i++) begin
      press(10'(1) << i);
      cyc(12);
      release_key();
      cyc(12);
    end

    // Reset in the middle of a press: abandoned, then a full accept restarts.
    key_raw = 10'h080;
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    check("rstpress_d", 32'(d), 32'd0);
    check("rstpress_valid", 32'(key_valid), 32'd0);
    check("rstpress_held", 32'(key_held), 32'd0);
    check("rstpress_multi", 32'(multi_err), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    exp_q.push_back('{1'b0, 10'h080, edge_cnt + LAT});
    cyc(12);

    // Reset while held clears outputs without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rstheld_d", 32'(d), 32'd0);
    check("rstheld_held", 32'(key_held), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    exp_q.push_back('{1'b0, 10'h080, edge_cnt + LAT});
    cyc(12);
    release_key();
    cyc(12);

    cyc(10);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
